// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe
// Description : Control-signal pipeline for a 5-stage in-order core. Carries
//               the main-decoder controls from ID through the ID/EX, EX/MEM
//               and MEM/WB registers, resolves taken branches in EX, squashes
//               the younger instruction on a taken branch and counts retired
//               instructions.
// Ports       :
//   clk, rst                         clock, synchronous active-high reset
//   valid_d                          ID-stage instruction is real
//   RegWriteD..BranchD, ImmSrcD,
//   ALUopD                           ID-stage decoder controls
//   stall_d                          hold ID/EX
//   flush_e                          insert a bubble into EX
//   ZeroE                            ALU zero flag of the EX instruction
//   *E, valid_e                      registered EX-stage controls
//   PCSrcE                           branch taken in EX
//   flush_d_o                        squash the instruction currently in ID
//   *M, valid_m                      registered MEM-stage controls
//   *W, valid_w                      registered WB-stage controls
//   retire_cnt                       number of valid instructions reaching WB
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_d,
  input  logic        RegWriteD,
  input  logic        MemWriteD,
  input  logic        ResultScrD,
  input  logic        ALUSrcD,
  input  logic        BranchD,
  input  logic [1:0]  ImmSrcD,
  input  logic [1:0]  ALUopD,
  input  logic        stall_d,
  input  logic        flush_e,
  input  logic        ZeroE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        ResultScrE,
  output logic        ALUSrcE,
  output logic        BranchE,
  output logic        valid_e,
  output logic [1:0]  ALUopE,
  output logic        PCSrcE,
  output logic        flush_d_o,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultScrM,
  output logic        valid_m,
  output logic        RegWriteW,
  output logic        ResultScrW,
  output logic        valid_w,
  output logic [15:0] retire_cnt
);

  // Immediate selection is consumed entirely in ID; nothing downstream uses it.
  logic w_unused_imm;
  assign w_unused_imm = ^ImmSrcD;

  // A taken branch only counts for a real instruction sitting in EX.
  assign PCSrcE    = BranchE & ZeroE & valid_e;
  assign flush_d_o = PCSrcE;

  // ID/EX: bubble (flush or taken branch) beats stall, stall beats load.
  // Write enables are qualified with valid so a bubble can never write.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteE  <= 1'b0;
      MemWriteE  <= 1'b0;
      ResultScrE <= 1'b0;
      ALUSrcE    <= 1'b0;
      BranchE    <= 1'b0;
      ALUopE     <= 2'b00;
      valid_e    <= 1'b0;
    end else if (flush_e || PCSrcE) begin
      RegWriteE  <= 1'b0;
      MemWriteE  <= 1'b0;
      ResultScrE <= 1'b0;
      ALUSrcE    <= 1'b0;
      BranchE    <= 1'b0;
      ALUopE     <= 2'b00;
      valid_e    <= 1'b0;
    end else if (!stall_d) begin
      RegWriteE  <= RegWriteD & valid_d;
      MemWriteE  <= MemWriteD & valid_d;
      ResultScrE <= ResultScrD;
      ALUSrcE    <= ALUSrcD;
      BranchE    <= BranchD;
      ALUopE     <= ALUopD;
      valid_e    <= valid_d;
    end
  end

  // EX/MEM and MEM/WB advance unconditionally outside reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultScrM <= 1'b0;
      valid_m    <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultScrW <= 1'b0;
      valid_w    <= 1'b0;
    end else begin
      RegWriteM  <= RegWriteE & valid_e;
      MemWriteM  <= MemWriteE & valid_e;
      ResultScrM <= ResultScrE;
      valid_m    <= valid_e;
      RegWriteW  <= RegWriteM & valid_m;
      ResultScrW <= ResultScrM;
      valid_w    <= valid_m;
    end
  end

  // Retirement counter: wraps naturally at 16 bits. Reset wins, so an
  // instruction sitting in WB on the reset edge is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= 16'h0000;
    end else if (valid_w) begin
      retire_cnt <= retire_cnt + 16'h0001;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_pipe
// Description : Randomised plus directed stimulus for ctrl_pipe. A reference
//               model tracks instruction records per stage; expected outputs
//               are queued by the stimulus and checked by a separate monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_d, RegWriteD, MemWriteD, ResultScrD, ALUSrcD, BranchD;
  logic [1:0]  ImmSrcD, ALUopD;
  logic        stall_d, flush_e, ZeroE;
  logic        RegWriteE, MemWriteE, ResultScrE, ALUSrcE, BranchE, valid_e;
  logic [1:0]  ALUopE;
  logic        PCSrcE, flush_d_o;
  logic        RegWriteM, MemWriteM, ResultScrM, valid_m;
  logic        RegWriteW, ResultScrW, valid_w;
  logic [15:0] retire_cnt;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .rst(rst), .valid_d(valid_d),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultScrD(ResultScrD),
    .ALUSrcD(ALUSrcD), .BranchD(BranchD), .ImmSrcD(ImmSrcD), .ALUopD(ALUopD),
    .stall_d(stall_d), .flush_e(flush_e), .ZeroE(ZeroE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultScrE(ResultScrE),
    .ALUSrcE(ALUSrcE), .BranchE(BranchE), .valid_e(valid_e), .ALUopE(ALUopE),
    .PCSrcE(PCSrcE), .flush_d_o(flush_d_o),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultScrM(ResultScrM),
    .valid_m(valid_m), .RegWriteW(RegWriteW), .ResultScrW(ResultScrW),
    .valid_w(valid_w), .retire_cnt(retire_cnt)
  );

  // One instruction as it travels down the pipe (raw decoder bits + valid).
  typedef struct packed {
    logic       valid, rw, mw, rs, as, br;
    logic [1:0] op;
  } instr_t;

  typedef struct packed {
    logic       rst, v, rw, mw, rs, as, br;
    logic [1:0] imm, op;
    logic       st, fl, z;
  } stim_t;

  typedef struct packed {
    logic [16:0] ctrl;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t   sb_q[$];
  instr_t m_e, m_m, m_w;
  logic [15:0] m_cnt;
  stim_t  cur;
  int     cycle = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  logic [16:0] act_ctrl;
  assign act_ctrl = {RegWriteE, MemWriteE, ResultScrE, ALUSrcE, BranchE, valid_e,
                     ALUopE, PCSrcE, flush_d_o, RegWriteM, MemWriteM, ResultScrM,
                     valid_m, RegWriteW, ResultScrW, valid_w};

  // Model of one clock edge using the inputs that were held during it.
  task automatic model_edge();
    logic taken;
    instr_t d;
    taken = m_e.valid && m_e.br && cur.z;
    d = '{valid: cur.v, rw: cur.rw, mw: cur.mw, rs: cur.rs, as: cur.as,
          br: cur.br, op: cur.op};
    if (cur.rst) begin
      m_e = '0; m_m = '0; m_w = '0; m_cnt = 16'd0;
    end else begin
      if (m_w.valid) m_cnt = m_cnt + 16'd1;
      m_w = m_m;
      m_m = m_e;
      if (cur.fl || taken) m_e = '0;
      else if (!cur.st)    m_e = d;
    end
  endtask

  // Expected outputs for the current model state under the current inputs.
  function automatic exp_t expect_now();
    exp_t x;
    logic taken;
    taken = m_e.valid && m_e.br && cur.z;
    x.ctrl = {m_e.valid & m_e.rw, m_e.valid & m_e.mw, m_e.rs, m_e.as, m_e.br,
              m_e.valid, m_e.op, taken, taken,
              m_m.valid & m_m.rw, m_m.valid & m_m.mw, m_m.rs, m_m.valid,
              m_w.valid & m_w.rw, m_w.rs, m_w.valid};
    x.cnt = m_cnt;
    x.cyc = cycle;
    return x;
  endfunction

  task automatic apply(input stim_t s);
    cur = s;
    rst = s.rst; valid_d = s.v; RegWriteD = s.rw; MemWriteD = s.mw;
    ResultScrD = s.rs; ALUSrcD = s.as; BranchD = s.br; ImmSrcD = s.imm;
    ALUopD = s.op; stall_d = s.st; flush_e = s.fl; ZeroE = s.z;
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    cycle++;
    model_edge();
    apply(s);
    sb_q.push_back(expect_now());
  endtask

  function automatic stim_t idle();
    return '0;
  endfunction

  function automatic stim_t lw();
    stim_t s = '0;
    s.v = 1'b1; s.rw = 1'b1; s.rs = 1'b1; s.as = 1'b1; s.imm = 2'b00;
    return s;
  endfunction

  function automatic stim_t beq();
    stim_t s = '0;
    s.v = 1'b1; s.br = 1'b1; s.op = 2'b01; s.imm = 2'b10;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst = ($urandom_range(0, 99) == 0);
    s.v   = ($urandom_range(0, 3) != 0);
    s.rw  = 1'($urandom);
    s.mw  = 1'($urandom);
    s.rs  = 1'($urandom);
    s.as  = 1'($urandom);
    s.br  = ($urandom_range(0, 3) == 0);
    s.imm = 2'($urandom);
    s.op  = 2'($urandom);
    s.st  = ($urandom_range(0, 5) == 0);
    s.fl  = ($urandom_range(0, 7) == 0);
    s.z   = 1'($urandom);
    return s;
  endfunction

  // Monitor: every cycle the DUT presents a full set of outputs; compare
  // against the oldest queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        n_checks++;
        if (act_ctrl !== x.ctrl) begin
          n_fail++;
          $display("FAIL ctrl cycle %0d: got %05h expected %05h", x.cyc, act_ctrl, x.ctrl);
        end
        n_checks++;
        if (retire_cnt !== x.cnt) begin
          n_fail++;
          $display("FAIL retire_cnt cycle %0d: got %04h expected %04h", x.cyc, retire_cnt, x.cnt);
        end
      end
    end
  end

  initial begin
    stim_t s;
    m_e = '0; m_m = '0; m_w = '0; m_cnt = 16'd0;
    s = idle(); s.rst = 1'b1;
    apply(s);
    step(s);                       // reset edge; reset state checked next
    step(idle());

    // lw pass-through
    step(lw());
    repeat (4) step(idle());

    // taken branch: beq enters E, ZeroE=1 while it is there
    step(beq());
    s = lw(); s.z = 1'b1;
    step(s);                       // beq in E, PCSrcE expected high
    repeat (4) step(idle());

    // not-taken branch followed by a normal load
    step(beq());
    s = lw(); s.z = 1'b0;
    step(s);
    repeat (4) step(idle());

    // load-use bubble
    step(lw());
    s = lw(); s.fl = 1'b1;
    step(s);
    step(lw());
    repeat (4) step(idle());

    // stall versus taken branch, then stall alone for two cycles
    step(beq());
    s = lw(); s.z = 1'b1; s.st = 1'b1;
    step(s);
    step(lw());
    s = idle(); s.st = 1'b1;
    step(s);
    step(s);
    repeat (4) step(idle());

    // reset with three valid instructions in flight
    step(lw()); step(lw()); step(lw());
    s = idle(); s.rst = 1'b1;
    step(s);
    step(idle());

    // randomised traffic
    for (int i = 0; i < 3000; i++) step(rnd());

    // counter wrap: 65536 retirements from a clean reset
    s = idle(); s.rst = 1'b1;
    step(s);
    for (int i = 0; i < 65536; i++) step(lw());
    repeat (4) step(idle());

    // drain: let the monitor consume the last expectation, bounded
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port valid_d, input, 1, the ID-stage instruction is real (not a bubble).
REQ-004 SHALL have ports RegWriteD, MemWriteD, ResultScrD, ALUSrcD and BranchD, each input, 1, the ID-stage control bits from the main decoder.
REQ-005 SHALL have ports ImmSrcD and ALUopD, each input, 2, the ID-stage control fields from the main decoder.
REQ-006 SHALL have port stall_d, input, 1, hazard-unit hold of the ID/EX register.
REQ-007 SHALL have port flush_e, input, 1, hazard-unit request to insert a bubble into the EX stage.
REQ-008 SHALL have port ZeroE, input, 1, the ALU zero flag for the EX-stage instruction.
REQ-009 SHALL have ports RegWriteE, MemWriteE, ResultScrE, ALUSrcE, BranchE and valid_e, each output, 1, the registered EX-stage controls.
REQ-010 SHALL have port ALUopE, output, 2, the registered EX-stage ALU operation.
REQ-011 SHALL have port PCSrcE, output, 1, branch taken in EX.
REQ-012 SHALL have port flush_d_o, output, 1, request to squash the instruction currently in ID.
REQ-013 SHALL have ports RegWriteM, MemWriteM, ResultScrM and valid_m, each output, 1, the registered MEM-stage controls.
REQ-014 SHALL have ports RegWriteW, ResultScrW and valid_w, each output, 1, the registered WB-stage controls.
REQ-015 SHALL have port retire_cnt, output, 16, the count of valid instructions that have reached WB.

Function
REQ-016 SHALL carry controls through three register stages, ID/EX -> EX/MEM -> MEM/WB, one cycle per stage; a D-stage input appears on the E outputs 1 cycle later, on M 2 cycles later and on W 3 cycles later.
REQ-017 SHALL drop ImmSrcD at ID/EX, because immediate selection is consumed in ID.
REQ-018 SHALL drop ALUSrcE, ALUopE and BranchE at EX/MEM, and drop MemWriteM at MEM/WB.
REQ-019 SHALL drive PCSrcE combinationally as BranchE AND ZeroE AND valid_e.
REQ-020 SHALL drive flush_d_o equal to PCSrcE.
REQ-021 SHALL define the ID/EX update priority, highest first: rst; then (flush_e OR PCSrcE); then stall_d; then normal load.
REQ-022 SHALL, on a bubble in ID/EX (flush_e OR PCSrcE), clear every E control and valid_e to 0.
REQ-023 SHALL, when stall_d=1 and there is no flush, make ID/EX hold its value while EX/MEM and MEM/WB still advance.
REQ-024 SHALL, on a normal load, have ID/EX capture the D inputs with valid_e = valid_d.
REQ-025 SHALL advance EX/MEM and MEM/WB every non-reset cycle, with no stall or flush on these stages.
REQ-026 SHALL, while a stage's valid bit is 0, force every write-enable of that stage (RegWrite*, MemWrite*) to 0, regardless of the D inputs.
REQ-027 SHALL increment retire_cnt by 1 on each rising edge where valid_w=1, wrapping from 0xFFFF to 0x0000.
REQ-028 SHALL, for a simultaneous stall_d and taken branch, apply the flush: the bubble wins over the hold.
REQ-029 SHALL, for a simultaneous flush_e and PCSrcE, insert a single bubble with no double effect.

Reset
REQ-030 SHALL, on rst=1 at a rising edge, clear all stage registers, all valid bits and retire_cnt to 0.
REQ-031 SHALL, after reset, drive PCSrcE=0 and flush_d_o=0.
REQ-032 SHALL give rst priority over stall_d, flush_e and PCSrcE.
REQ-033 SHALL, on rst asserted mid-stream, discard all in-flight instructions without incrementing retire_cnt on that edge.
REQ-034 SHALL clear state on the first clocked edge with rst=1, with no asynchronous path.

Verification
REQ-035 SHALL cover the lw pass-through scenario: valid_d=1, RegWriteD=1, ResultScrD=1, ALUSrcD=1 for 1 cycle -> the E outputs show these values at cycle 1, RegWriteM=ResultScrM=1 at cycle 2, RegWriteW=ResultScrW=1 at cycle 3, and retire_cnt=1 after cycle 3.
REQ-036 SHALL cover the taken-branch scenario: beq with BranchD=1, ALUopD=01 enters E, ZeroE=1 -> PCSrcE=1 and flush_d_o=1 in that cycle; the next cycle shows valid_e=0 with all E controls 0; the branch itself reaches W with RegWriteW=0.
REQ-037 SHALL cover the not-taken-branch scenario: BranchE=1, ZeroE=0 -> PCSrcE=0 and the following instruction loads normally.
REQ-038 SHALL cover the load-use bubble scenario: flush_e=1 for 1 cycle -> valid_e=0 next cycle, and retire_cnt shows one fewer increment than the number of issued instructions.
REQ-039 SHALL cover the stall-versus-branch scenario: stall_d=1 with PCSrcE=1 in the same cycle -> ID/EX is cleared, not held; with stall_d=1 alone, the E outputs stay constant for 2 cycles while M and W advance.
REQ-040 SHALL cover the reset-and-wrap scenario: rst asserted with 3 valid instructions in flight -> all outputs 0 next edge; preloading via 65536 retirements -> retire_cnt wraps to 0x0000.
